rtmq_reg_arb: RTL and testbench
===============================

Name: rtmq_reg_arb

Overview:
- Shares one W_REG-wide peripheral register between two writers: the RTMQ core and an external host port (UART/debug bridge).
- Core access uses the per-address flags produced by the core's access-flag decoder, plus the ALU/immediate data fields. Core writes always win.
- Host accesses use a 4-phase req/ack handshake and are applied only on cycles with no core write.
- Sits beside each host-visible register in the RTMQ peripheral map.

Parameters:
- W_REG, 32: register width; must be even.
- RST_VAL, 0: register value after reset.
- STARVE_MAX, 15: number of consecutive deferred host cycles before a forced host slot. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- f_read  in  1  core read flag (registered flag from decoder)
- f_wrt_alu  in  1  core ALU-channel write flag
- f_wrt_ihi  in  1  core immediate write flag, upper half
- f_wrt_ilo  in  1  core immediate write flag, lower half
- alu_res  in  W_REG  ALU result
- alu_msk  in  W_REG  ALU bit-write mask
- imm_res  in  W_REG  immediate value; only bits [W_REG/2-1:0] are used
- host_req  in  1  host request (level, 4-phase)
- host_we  in  1  host write enable, sampled with host_req
- host_wdat  in  W_REG  host write data
- host_ack  out  1  host acknowledge
- host_rdat  out  W_REG  host read data, valid while host_ack is high
- reg_q  out  W_REG  current register value; also drives the core read mux
- wr_strobe  out  1  one-cycle pulse on any register update
- core_hold  out  1  core stall request (optional feature only, else tied 0)

Behaviour:
- Reset (async, rst_n=0): reg_q=RST_VAL, host_ack=0, host_rdat=0, wr_strobe=0, core_hold=0, FSM=IDLE, starve counter=0. Reset mid-handshake aborts the transaction with no write.
- Core write (cycle N flags -> reg_q updated at edge N+1):
  - f_wrt_alu: reg_q <= (reg_q & ~alu_msk) | (alu_res & alu_msk).
  - f_wrt_ihi: reg_q[W_REG-1:W_REG/2] <= imm_res[W_REG/2-1:0].
  - f_wrt_ilo: reg_q[W_REG/2-1:0] <= imm_res[W_REG/2-1:0].
  - Simultaneous flags: the ALU merge is applied first, then the immediate halves override their bits.
- f_read has no side effect. It is counted as a core-busy cycle for host arbitration.
- "Core busy" = any of f_wrt_alu, f_wrt_ihi, f_wrt_ilo, f_read is high.
- FSM:
  - IDLE: host_req=1 -> PEND; latch host_we and host_wdat.
  - PEND: if core busy, stay in PEND (defer). Otherwise perform the access at this edge:
    - write: reg_q <= latched data, wr_strobe=1.
    - read: host_rdat <= reg_q.
    - Then -> ACK.
  - ACK: host_ack=1. When host_req=0 -> IDLE with host_ack=0.
  - Minimum latency: host_req rising to host_ack high = 2 cycles.
- host_wdat/host_we changes after latching are ignored.
- host_req dropping while in PEND: cancel, return to IDLE, no write.
- wr_strobe: one cycle after any reg_q change. Rewriting an identical value still pulses.

Optional Feature:
- Macro: RTMQ_ARB_STARVE_EN.
- Defined:
  - A counter increments on each deferred PEND cycle.
  - When it reaches STARVE_MAX, core_hold=1 for exactly one cycle. The core must not issue a write in the following cycle.
  - The host access is performed in that cycle and the counter clears.
  - The counter also clears when the host access completes.
- Undefined: no counter; core_hold is constant 0, so the host may wait indefinitely.

Test Plan:
- Reset with RST_VAL=0x12345678 -> reg_q=0x12345678, host_ack=0. Assert rst_n=0 mid-PEND -> back to IDLE, reg_q=RST_VAL.
- Core write: reg_q=0xFFFF0000, f_wrt_alu with alu_res=0x0000AAAA, alu_msk=0x0000FFFF -> reg_q=0xFFFFAAAA, wr_strobe one pulse.
- Same cycle f_wrt_alu (res=0x11111111, msk=all ones) and f_wrt_ilo (imm_res=0xBEEF) -> reg_q=0x1111BEEF.
- Host write 0xCAFEF00D, no core activity -> reg_q updated 2 edges after req, host_ack high until req drops, then low next cycle.
- Host read while core writes for 5 consecutive cycles (alu_res=0x5, msk all ones) -> ack deferred 5 cycles; host_rdat=0x00000005.
- With RTMQ_ARB_STARVE_EN, STARVE_MAX=4 and continuous core writes -> core_hold pulses once after 4 deferrals, host write lands in that cycle, counter resets.

Source files
------------

// File: rtl/rtmq_reg_arb.sv
// rtmq_reg_arb: one W_REG-wide peripheral register shared by the RTMQ core
// and a host port that uses a 4-phase req/ack handshake. Core writes always
// win. The host gets a slot only on cycles where the core is idle.
// Optional build macro RTMQ_ARB_STARVE_EN: after STARVE_MAX deferred host
// cycles, core_hold pulses for one cycle and the host gets a forced slot.
module rtmq_reg_arb #(
  parameter int unsigned       W_REG      = 32,
  parameter logic [W_REG-1:0]  RST_VAL    = '0,
  parameter int unsigned       STARVE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_read,
  input  logic             f_wrt_alu,
  input  logic             f_wrt_ihi,
  input  logic             f_wrt_ilo,
  input  logic [W_REG-1:0] alu_res,
  input  logic [W_REG-1:0] alu_msk,
  input  logic [W_REG-1:0] imm_res,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [W_REG-1:0] host_wdat,
  output logic             host_ack,
  output logic [W_REG-1:0] host_rdat,
  output logic [W_REG-1:0] reg_q,
  output logic             wr_strobe,
  output logic             core_hold
);

  localparam int unsigned HALF = W_REG / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  logic             lat_we;
  logic [W_REG-1:0] lat_dat;

  logic             core_wr_c;
  logic             core_busy_c;
  logic             force_c;
  logic             host_slot_c;
  logic             core_apply_c;
  logic [W_REG-1:0] core_val_c;

  // Only the lower half of the immediate bus carries data
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_res[W_REG-1:HALF];

`ifdef RTMQ_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;
  assign force_c = core_hold;
`else
  logic unused_starve;
  assign unused_starve = (STARVE_MAX == 0);
  assign force_c       = 1'b0;
  assign core_hold     = 1'b0;
`endif

  // Core write value: ALU masked merge first, immediate halves override
  always_comb begin
    core_val_c = reg_q;
    if (f_wrt_alu) core_val_c = (reg_q & ~alu_msk) | (alu_res & alu_msk);
    if (f_wrt_ihi) core_val_c[W_REG-1:HALF] = imm_res[HALF-1:0];
    if (f_wrt_ilo) core_val_c[HALF-1:0]     = imm_res[HALF-1:0];
  end

  // Arbitration: host slot only when core idle, or when forced by starvation
  always_comb begin
    core_wr_c    = f_wrt_alu | f_wrt_ihi | f_wrt_ilo;
    core_busy_c  = core_wr_c | f_read;
    host_slot_c  = (state == PEND) && host_req && (!core_busy_c || force_c);
    core_apply_c = core_wr_c && !host_slot_c;
  end

  // Handshake FSM, register update and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_dat    <= '0;
      reg_q      <= RST_VAL;
      host_ack   <= 1'b0;
      host_rdat  <= '0;
      wr_strobe  <= 1'b0;
`ifdef RTMQ_ARB_STARVE_EN
      starve_cnt <= '0;
      core_hold  <= 1'b0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      if (core_apply_c) begin
        reg_q     <= core_val_c;
        wr_strobe <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (host_req) begin
            state   <= PEND;
            lat_we  <= host_we;
            lat_dat <= host_wdat;
          end
        end
        PEND: begin
          if (!host_req) begin
            state <= IDLE;
`ifdef RTMQ_ARB_STARVE_EN
            starve_cnt <= '0;
            core_hold  <= 1'b0;
`endif
          end else if (host_slot_c) begin
            if (lat_we) begin
              reg_q     <= lat_dat;
              wr_strobe <= 1'b1;
            end else begin
              host_rdat <= reg_q;
            end
            host_ack <= 1'b1;
            state    <= ACK;
`ifdef RTMQ_ARB_STARVE_EN
            starve_cnt <= '0;
            core_hold  <= 1'b0;
`endif
          end else begin
`ifdef RTMQ_ARB_STARVE_EN
            starve_cnt <= starve_cnt + CNT_W'(1);
            if (starve_cnt == CNT_W'(STARVE_MAX - 1)) core_hold <= 1'b1;
`endif
          end
        end
        ACK: begin
          if (!host_req) begin
            host_ack <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          host_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtmq_reg_arb.sv
// Scoreboard bench for rtmq_reg_arb: stimulus pushes expected register
// updates and acknowledges; a negedge monitor pops and compares them.
module tb_rtmq_reg_arb;

  localparam logic [31:0] RST_V = 32'h12345678;
  localparam logic [31:0] ONES  = 32'hFFFF_FFFF;
`ifdef RTMQ_ARB_STARVE_EN
  localparam int NDEF = 3;
`else
  localparam int NDEF = 5;
`endif

  logic        clk;
  logic        rst_n;
  logic        f_read, f_wrt_alu, f_wrt_ihi, f_wrt_ilo;
  logic [31:0] alu_res, alu_msk, imm_res;
  logic        host_req, host_we;
  logic [31:0] host_wdat;
  logic        host_ack;
  logic [31:0] host_rdat;
  logic [31:0] reg_q;
  logic        wr_strobe;
  logic        core_hold;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] rdat;
  } ack_t;

  logic [31:0] wr_q[$];
  ack_t        ack_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        ack_d    = 1'b0;

  rtmq_reg_arb #(.W_REG(32), .RST_VAL(RST_V), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_read(f_read), .f_wrt_alu(f_wrt_alu), .f_wrt_ihi(f_wrt_ihi), .f_wrt_ilo(f_wrt_ilo),
    .alu_res(alu_res), .alu_msk(alu_msk), .imm_res(imm_res),
    .host_req(host_req), .host_we(host_we), .host_wdat(host_wdat),
    .host_ack(host_ack), .host_rdat(host_rdat),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .core_hold(core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT presents a strobe or ack edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_strobe) begin
        if (wr_q.size() == 0) chk("wr_strobe_unexpected", reg_q, 32'hxxxx_xxxx);
        else chk("reg_q_update", reg_q, wr_q.pop_front());
      end
      if (host_ack && !ack_d) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 32'(cyc), 32'hxxxx_xxxx);
        else begin
          ack_t a;
          a = ack_q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(a.cyc));
          if (a.rd) chk("host_rdat", host_rdat, a.rdat);
        end
      end
    end
    ack_d = host_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input bit alu, input bit ihi, input bit ilo, input bit rd,
                         input logic [31:0] res, input logic [31:0] msk,
                         input logic [31:0] imm, input bit exp_wr, input logic [31:0] exp_v);
    f_wrt_alu = alu; f_wrt_ihi = ihi; f_wrt_ilo = ilo; f_read = rd;
    alu_res = res; alu_msk = msk; imm_res = imm;
    if (exp_wr) wr_q.push_back(exp_v);
    tick();
  endtask

  task automatic core_idle();
    f_wrt_alu = 1'b0; f_wrt_ihi = 1'b0; f_wrt_ilo = 1'b0; f_read = 1'b0;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!host_ack && n < 40) begin
      tick();
      n++;
    end
    chk("ack_seen", 32'(host_ack), 32'd1);
  endtask

  // Host access with ndef core-write cycles (value val) right after latching
  task automatic host_deferred(input bit we, input logic [31:0] wdat, input int ndef,
                               input logic [31:0] val);
    int k;
    ack_t a;
    k = cyc;
    host_req = 1'b1; host_we = we; host_wdat = wdat;
    a.cyc = k + 2 + ndef; a.rd = !we; a.rdat = val;
    ack_q.push_back(a);
    tick();
    host_wdat = ~wdat; host_we = !we;
    for (int i = 0; i < ndef; i++) begin
      core_op(1'b1, 1'b0, 1'b0, 1'b0, val, ONES, 32'h0, 1'b1, val);
      chk("no_core_hold", 32'(core_hold), 32'd0);
    end
    core_idle();
    if (we) wr_q.push_back(wdat);
    wait_ack();
    tick();
    chk("ack_held", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    tick();
    chk("ack_drop", 32'(host_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    core_idle();
    alu_res = '0; alu_msk = '0; imm_res = '0;
    host_req = 1'b0; host_we = 1'b0; host_wdat = '0;
    tick();
    tick();
    chk("rst_reg_q", reg_q, RST_V);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_rdat", host_rdat, 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd0);
    rst_n = 1'b1;
    tick();

    // Core writes: masked merge, immediate halves, priority, identical rewrite
    core_op(1, 0, 0, 0, 32'hFFFF0000, ONES,         32'h0,        1, 32'hFFFF0000);
    core_op(1, 0, 0, 0, 32'h0000AAAA, 32'h0000FFFF, 32'h0,        1, 32'hFFFFAAAA);
    core_op(1, 0, 1, 0, 32'h11111111, ONES,         32'h0000BEEF, 1, 32'h1111BEEF);
    core_op(0, 1, 0, 0, 32'h0,        32'h0,        32'hFFFFDEAD, 1, 32'hDEADBEEF);
    core_op(0, 0, 0, 1, 32'h0,        ONES,         32'h0,        0, 32'h0);
    core_op(0, 0, 1, 0, 32'h0,        32'h0,        32'h1234BEEF, 1, 32'hDEADBEEF);
    core_op(1, 1, 1, 0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0000C0DE, 1, 32'hC0DEC0DE);
    core_op(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'hC0DEC0DE);
    core_idle();
    tick();
    chk("core_final", reg_q, 32'hC0DEC0DE);

    // Host write, no core activity: minimum latency
    host_deferred(1'b1, 32'hCAFEF00D, 0, 32'h0);
    chk("host_wr_val", reg_q, 32'hCAFEF00D);

    // Host read deferred by consecutive core writes
    host_deferred(1'b0, 32'h0, NDEF, 32'h00000005);

    // Cancel while pending: no write, no ack
    host_req = 1'b1; host_we = 1'b1; host_wdat = 32'h0BADBAD0; f_read = 1'b1;
    tick();
    tick();
    host_req = 1'b0; f_read = 1'b0;
    tick();
    tick();
    chk("cancel_reg_q", reg_q, 32'h00000005);
    chk("cancel_ack", 32'(host_ack), 32'd0);
    host_deferred(1'b0, 32'h0, 0, 32'h00000005);

`ifdef RTMQ_ARB_STARVE_EN
    // Starvation: 4 deferrals then a one-cycle core_hold with forced host write
    begin
      int k;
      ack_t a;
      k = cyc;
      host_req = 1'b1; host_we = 1'b1; host_wdat = 32'hA5A5A5A5;
      for (int i = 0; i < 5; i++)
        core_op(1, 0, 0, 0, 32'h100 + 32'(i), ONES, 32'h0, 1, 32'h100 + 32'(i));
      core_idle();
      chk("hold_cycle", 32'(cyc), 32'(k + 5));
      chk("core_hold_on", 32'(core_hold), 32'd1);
      wr_q.push_back(32'hA5A5A5A5);
      a.cyc = k + 6; a.rd = 1'b0; a.rdat = 32'h0;
      ack_q.push_back(a);
      tick();
      chk("core_hold_off", 32'(core_hold), 32'd0);
      chk("forced_ack", 32'(host_ack), 32'd1);
      chk("forced_wr", reg_q, 32'hA5A5A5A5);
      host_req = 1'b0;
      tick();
    end
    host_deferred(1'b0, 32'h0, 3, 32'h00000033);
`endif

    // Reset in the middle of a pending host write
    host_req = 1'b1; host_we = 1'b1; host_wdat = 32'h77777777; f_read = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_q", reg_q, RST_V);
    chk("midrst_ack", 32'(host_ack), 32'd0);
    host_req = 1'b0; f_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("postrst_reg_q", reg_q, RST_V);
    chk("postrst_ack", 32'(host_ack), 32'd0);

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
